// File: rtl/kpg_pkg.sv
// Shared kill/propagate/generate definitions for the prefix adder datapath.
package kpg_pkg;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_K = 2'b00;
    localparam kpg_t KPG_P = 2'b01;
    localparam kpg_t KPG_G = 2'b11;

    // Classify one bit column: both ones generate, both zeros kill, else propagate.
    function automatic kpg_t encode_bit(input logic a, input logic b);
        if (a & b) begin
            return KPG_G;
        end else if (~a & ~b) begin
            return KPG_K;
        end else begin
            return KPG_P;
        end
    endfunction

endpackage

// File: rtl/kpg_combine.sv
// KPG combine cell: a propagating upper group defers to the lower group.
module kpg_combine
    import kpg_pkg::*;
(
    input  kpg_t hi,
    input  kpg_t lo,
    output kpg_t out
);

    assign out = (hi == KPG_P) ? lo : hi;

endmodule

// File: rtl/kpg_prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: encode stage, one register per
// prefix level, registered sum stage, global-enable valid/ready flow control.
module kpg_prefix_adder_pipe
    import kpg_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    // Code index j holds bit position j-1; index 0 is the carry-in column.
    logic              adv;
    logic [WIDTH-1:0]  bp;
    kpg_t [WIDTH:0]    enc;
    kpg_t [WIDTH:0]    code_q [0:LEVELS];
    kpg_t [WIDTH:0]    code_d [1:LEVELS];
    logic [WIDTH-1:0]  x_q    [0:LEVELS];
    logic [LEVELS:0]   vld_q;

    kpg_t [WIDTH:0]    res_code;
    kpg_t              msb_code;
    logic [WIDTH-1:0]  carry_vec;
    logic [WIDTH-1:0]  sum_d;
    logic              cout_d;
    logic              ovf_d;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign bp       = sub ? ~b : b;

    // Encode every bit column plus the carry-in column.
    always_comb begin
        enc    = '0;
        enc[0] = (sub | cin) ? KPG_G : KPG_K;
        for (int i = 0; i < WIDTH; i++) begin
            enc[i+1] = encode_bit(a[i], bp[i]);
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int D = 2 ** (l - 1);
        for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
            if (j >= D) begin : g_cmb
                kpg_combine u_cmb (
                    .hi  (code_q[l-1][j]),
                    .lo  (code_q[l-1][j-D]),
                    .out (code_d[l][j])
                );
            end else begin : g_pass
                assign code_d[l][j] = code_q[l-1][j];
            end
        end
    end

    // Datapath pipeline registers; no reset, they only matter alongside a valid.
    always_ff @(posedge clk) begin
        if (adv) begin
            code_q[0] <= enc;
            x_q[0]    <= a ^ bp;
            for (int l = 1; l <= LEVELS; l++) begin
                code_q[l] <= code_d[l];
                x_q[l]    <= x_q[l-1];
            end
        end
    end

    // Valid shift chain; bubbles travel with the data and never collapse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[LEVELS-1:0], in_valid};
        end
    end

    assign res_code = code_q[LEVELS];

    // The MSB span after LEVELS levels stops one short of the carry-in column,
    // so it takes one last combine with the (always resolved) carry-in.
    kpg_combine u_msb (
        .hi  (res_code[WIDTH]),
        .lo  (res_code[0]),
        .out (msb_code)
    );

    // Carry into bit i is the resolved code at index i.
    always_comb begin
        carry_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry_vec[i] = (res_code[i] == KPG_G);
        end
    end

    assign sum_d  = x_q[LEVELS] ^ carry_vec;
    assign cout_d = (msb_code == KPG_G);
    assign ovf_d  = cout_d ^ (res_code[WIDTH-1] == KPG_G);

    // Output stage; holds steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= vld_q[LEVELS];
            sum       <= sum_d;
            cout      <= cout_d;
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_kpg_prefix_adder_pipe.sv
// Bench for kpg_prefix_adder_pipe: directed 8-bit vectors, stream with stall,
// reset mid-flight, and random 32/64-bit streams against an a +/- b model.
module tb_kpg_prefix_adder_pipe;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
    logic [7:0]  a8, b8, s8;
    logic        iv32, ir32, ov32, or32, cin32, sub32, co32, of32;
    logic [31:0] a32, b32, s32;
    logic        iv64, ir64, ov64, or64, cin64, sub64, co64, of64;
    logic [63:0] a64, b64, s64;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
        int          t;
    } exp_t;

    vec_t tbl [14];
    exp_t q8[$], q32[$], q64[$];

    always #5 clk = ~clk;

    kpg_prefix_adder_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(of8)
    );

    kpg_prefix_adder_pipe #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
        .cout(co32), .ovf(of32)
    );

    kpg_prefix_adder_pipe #(.WIDTH(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64), .sum(s64),
        .cout(co64), .ovf(of64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 25) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural w-bit a +/- b: returns {ovf, cout, sum}.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [64:0] mask, bp, full;
        logic [63:0] s;
        logic        co, ov;
        mask = (65'd1 << w) - 65'd1;
        bp   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        full = ({1'b0, a} & mask) + bp + {64'd0, (sub | cin)};
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (a[w-1] == bp[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                          output logic [7:0] s, output logic co, output logic ov, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = s8; co = co8; ov = of8;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rs;
        logic        rco, rov;
        int          lat, sent, got, cyc, nv;
        logic        acc;
        logic [65:0] m;
        exp_t        e;
        logic [63:0] aw, bw;
        logic        cw, sw, ivw;

        tbl[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[3]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[4]  = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[6]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[8]  = '{8'h12, 8'h34, 1'b0, 1'b1, 8'hDE, 1'b0, 1'b0};
        tbl[9]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[11] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[12] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        tbl[13] = '{8'h80, 8'h7F, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        // Reset with in_valid held high.
        rst_n = 1'b0;
        iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0; or8 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;
        iv64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0; or64 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(ov8), 64'd0);
        chk("rst_sum", 64'(s8), 64'd0);
        chk("rst_cout", 64'(co8), 64'd0);
        chk("rst_ovf", 64'(of8), 64'd0);
        rst_n = 1'b1;
        iv8 = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(ir8), 64'd1);
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov8) nv++;
        end
        chk("rst_no_output", 64'(nv), 64'd0);

        // Directed vectors, one at a time.
        for (int i = 0; i < 14; i++) begin
            apply8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rco, rov, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
            chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(tbl[i].s));
            chk($sformatf("vec%0d_cout", i), 64'(rco), 64'(tbl[i].co));
            chk($sformatf("vec%0d_ovf", i), 64'(rov), 64'(tbl[i].ov));
        end

        // Back-to-back stream with a three-cycle downstream stall.
        sent = 0; got = 0; cyc = 0; acc = 1'b0;
        while (got < 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            or8 = !(cyc >= 10 && cyc <= 12);
            if (acc || !iv8) begin
                if (sent < 20) begin
                    a8 = 8'($urandom); b8 = 8'($urandom);
                    cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
                    iv8 = 1'b1;
                end else begin
                    iv8 = 1'b0;
                end
            end
            #1;
            if (!or8 && ov8 && q8.size() > 0) begin
                chk("stall_in_ready", 64'(ir8), 64'd0);
                chk("stall_sum", 64'(s8), q8[0].s);
                chk("stall_cout", 64'(co8), 64'(q8[0].co));
                chk("stall_ovf", 64'(of8), 64'(q8[0].ov));
            end
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    chk("stream_extra_output", 64'd1, 64'd0);
                end else begin
                    e = q8.pop_front();
                    chk($sformatf("stream%0d_sum", got), 64'(s8), e.s);
                    chk($sformatf("stream%0d_cout", got), 64'(co8), 64'(e.co));
                    chk($sformatf("stream%0d_ovf", got), 64'(of8), 64'(e.ov));
                end
                got++;
            end
            acc = iv8 && ir8;
            if (acc) begin
                m = model(8, {56'd0, a8}, {56'd0, b8}, cin8, sub8);
                q8.push_back('{m[63:0], m[64], m[65], cyc});
                sent++;
            end
        end
        iv8 = 1'b0; or8 = 1'b1;
        chk("stream_count", 64'(got), 64'd20);
        chk("stream_leftover", 64'(q8.size()), 64'd0);

        // Reset with three operations in flight.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a8 = 8'(k + 1); b8 = 8'h10; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        end
        @(negedge clk);
        iv8 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_out_valid", 64'(ov8), 64'd0);
        chk("midrst_in_ready", 64'(ir8), 64'd1);
        rst_n = 1'b1;
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov8) nv++;
        end
        chk("midrst_discarded", 64'(nv), 64'd0);
        apply8(8'h01, 8'h01, 1'b0, 1'b0, rs, rco, rov, lat);
        chk("midrst_fresh_latency", 64'(lat), 64'd5);
        chk("midrst_fresh_sum", 64'(rs), 64'h02);

        // Random 32- and 64-bit streams, full throughput, fixed latency.
        cyc = 0;
        for (int n = 0; n < 10020; n++) begin
            @(negedge clk);
            cyc++;
            if (n < 10000) begin
                aw = {$urandom, $urandom}; bw = {$urandom, $urandom};
                cw = 1'($urandom_range(0, 1)); sw = 1'($urandom_range(0, 1));
                ivw = ($urandom_range(0, 3) != 0);
            end else begin
                ivw = 1'b0;
            end
            a32 = aw[31:0]; b32 = bw[31:0]; cin32 = cw; sub32 = sw; iv32 = ivw;
            a64 = aw;       b64 = bw;       cin64 = cw; sub64 = sw; iv64 = ivw;
            #1;
            if (ov32) begin
                if (q32.size() == 0) begin
                    chk("w32_extra_output", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    chk("w32_sum", {32'd0, s32}, e.s);
                    chk("w32_cout", 64'(co32), 64'(e.co));
                    chk("w32_ovf", 64'(of32), 64'(e.ov));
                    chk("w32_latency", 64'(cyc - e.t), 64'd7);
                end
            end
            if (ov64) begin
                if (q64.size() == 0) begin
                    chk("w64_extra_output", 64'd1, 64'd0);
                end else begin
                    e = q64.pop_front();
                    chk("w64_sum", s64, e.s);
                    chk("w64_cout", 64'(co64), 64'(e.co));
                    chk("w64_ovf", 64'(of64), 64'(e.ov));
                    chk("w64_latency", 64'(cyc - e.t), 64'd8);
                end
            end
            if (iv32 && ir32) begin
                m = model(32, {32'd0, a32}, {32'd0, b32}, cin32, sub32);
                q32.push_back('{m[63:0], m[64], m[65], cyc});
            end
            if (iv64 && ir64) begin
                m = model(64, a64, b64, cin64, sub64);
                q64.push_back('{m[63:0], m[64], m[65], cyc});
            end
        end
        chk("w32_leftover", 64'(q32.size()), 64'd0);
        chk("w64_leftover", 64'(q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
